// File: rtl/knn_point_streamer.sv
// rtl/knn_point_streamer.sv - buffers host query elements and issues them one dimension per cycle with point tags
module knn_point_streamer #(
    parameter int dataWidth = 32,
    parameter int fifoDepth = 16,
    parameter int addrWidth = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [31:0]          numberOfDimensions,
    input  logic [31:0]          numberOfPoints,
    input  logic                 inValid,
    input  logic [dataWidth-1:0] inData,
    output logic                 inReady,
    output logic                 dataValid,
    output logic [dataWidth-1:0] dataValueOut,
    output logic [31:0]          dataNameOut,
    output logic                 lastDim,
    output logic                 busy,
    output logic                 done,
    output logic                 cfgErr
);
    typedef enum logic [1:0] {IDLE, STREAM, DONE} stateType;

    localparam logic [addrWidth:0]   fullCount = (addrWidth + 1)'(fifoDepth);
    localparam logic [addrWidth-1:0] ptrStep   = 1;

    stateType             state, nextState;
    logic [dataWidth-1:0] mem [fifoDepth];
    logic [addrWidth-1:0] wrPtr, rdPtr;
    logic [addrWidth:0]   count;
    logic [31:0]          nd, np, inDim, inPt, outDim, outPt;
    logic                 acceptComplete, issueComplete;
    logic                 fifoFull, fifoEmpty, push, pop, startOk, cfgZero;
    logic                 inLastDim, outLastDim, lastAccept, lastIssue;

    assign fifoFull   = (count == fullCount);
    assign fifoEmpty  = (count == '0);
    assign cfgZero    = (numberOfDimensions == 32'd0) || (numberOfPoints == 32'd0);
    assign startOk    = (state == IDLE) && start && !abort;
    // abort also masks inReady so the host never sees a handshake that is then dropped
    assign inReady    = (state == STREAM) && !fifoFull && !acceptComplete && !abort;
    assign push       = inValid && inReady;
    // pop uses the registered count, so a freshly pushed element leaves one cycle later
    assign pop        = (state == STREAM) && !fifoEmpty && !abort;
    assign inLastDim  = (inDim == nd - 32'd1);
    assign outLastDim = (outDim == nd - 32'd1);
    assign lastAccept = inLastDim && (inPt == np - 32'd1);
    assign lastIssue  = pop && outLastDim && (outPt == np - 32'd1);
    assign busy       = (state == STREAM);
    assign done       = (state == DONE);

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // next-state: STREAM leaves one cycle after the final element has been presented
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = cfgZero ? DONE : STREAM;
            STREAM:  if (issueComplete) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (abort) begin
            nextState = IDLE;
        end
    end

    // FIFO storage, kept out of the reset domain so it can map onto a RAM
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= inData;
        end
    end

    // run configuration, FIFO pointers, accept/issue counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nd             <= '0;
            np             <= '0;
            wrPtr          <= '0;
            rdPtr          <= '0;
            count          <= '0;
            inDim          <= '0;
            inPt           <= '0;
            outDim         <= '0;
            outPt          <= '0;
            acceptComplete <= 1'b0;
            issueComplete  <= 1'b0;
            dataValid      <= 1'b0;
            dataValueOut   <= '0;
            dataNameOut    <= '0;
            lastDim        <= 1'b0;
            cfgErr         <= 1'b0;
        end else if (abort) begin
            wrPtr          <= '0;
            rdPtr          <= '0;
            count          <= '0;
            inDim          <= '0;
            inPt           <= '0;
            outDim         <= '0;
            outPt          <= '0;
            acceptComplete <= 1'b0;
            issueComplete  <= 1'b0;
            dataValid      <= 1'b0;
        end else begin
            if (startOk) begin
                nd             <= numberOfDimensions;
                np             <= numberOfPoints;
                cfgErr         <= cfgZero;
                inDim          <= '0;
                inPt           <= '0;
                outDim         <= '0;
                outPt          <= '0;
                acceptComplete <= 1'b0;
                issueComplete  <= 1'b0;
            end
            if (push) begin
                wrPtr <= wrPtr + ptrStep;
                if (inLastDim) begin
                    inDim <= '0;
                    inPt  <= inPt + 32'd1;
                end else begin
                    inDim <= inDim + 32'd1;
                end
                if (lastAccept) begin
                    acceptComplete <= 1'b1;
                end
            end
            if (pop) begin
                rdPtr        <= rdPtr + ptrStep;
                dataValueOut <= mem[rdPtr];
                dataNameOut  <= outPt;
                lastDim      <= outLastDim;
                if (outLastDim) begin
                    outDim <= '0;
                    outPt  <= outPt + 32'd1;
                end else begin
                    outDim <= outDim + 32'd1;
                end
                if (lastIssue) begin
                    issueComplete <= 1'b1;
                end
            end
            dataValid <= pop;
            count     <= count + {{addrWidth{1'b0}}, push} - {{addrWidth{1'b0}}, pop};
        end
    end
endmodule

// File: tb/tb_knn_point_streamer.sv
// tb/tb_knn_point_streamer.sv - self-checking bench for knn_point_streamer
module tb_knn_point_streamer;
    localparam int depth = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        inValid = 1'b0;
    logic [31:0] numberOfDimensions = '0;
    logic [31:0] numberOfPoints = '0;
    logic [31:0] inData = '0;
    logic        inReady, dataValid, lastDim, busy, done, cfgErr;
    logic [31:0] dataValueOut, dataNameOut;

    int tests = 0;
    int fails = 0;
    int quietErrs;

    typedef struct {
        int nd;
        int np;
        int mode;
        int abortAt;
        bit expCfg;
        int expDone;
    } vecT;

    vecT vecs[$];
    vecT r;

    knn_point_streamer dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .numberOfDimensions(numberOfDimensions),
        .numberOfPoints(numberOfPoints),
        .inValid(inValid),
        .inData(inData),
        .inReady(inReady),
        .dataValid(dataValid),
        .dataValueOut(dataValueOut),
        .dataNameOut(dataNameOut),
        .lastDim(lastDim),
        .busy(busy),
        .done(done),
        .cfgErr(cfgErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        check({tag, ".flags"}, {inReady, dataValid, lastDim, busy, done, cfgErr}, 0);
        check({tag, ".value"}, dataValueOut, 0);
        check({tag, ".name"}, dataNameOut, 0);
    endtask

    task automatic doRun(input int idx, input vecT v);
        int total = v.nd * v.np;
        int sent = 0;
        int seen = 0;
        int doneCnt = 0;
        int errs = 0;
        int post = 0;
        logic [31:0] expQ[$];
        logic [31:0] e;
        bit expBusy, expReady;
        string tag = $sformatf("run%0d", idx);

        @(negedge clk);
        inValid = 1'b0;
        numberOfDimensions = v.nd;
        numberOfPoints = v.np;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".cfgErr"}, cfgErr, v.expCfg);
        if (v.nd == 0 || v.np == 0) begin
            check({tag, ".cfgDone"}, {done, dataValid, busy}, 3'b100);
            @(negedge clk);
            check({tag, ".cfgIdle"}, {done, dataValid, busy, cfgErr}, 4'b0001);
            return;
        end

        for (int cyc = 0; cyc < 3000; cyc++) begin
            expBusy = (seen < total);
            if (busy !== expBusy) errs++;
            if (dataValid === 1'b1) begin
                if (expQ.size() == 0) begin
                    errs++;
                end else begin
                    e = expQ.pop_front();
                    if (dataValueOut !== e || dataNameOut !== 32'(seen / v.nd) ||
                        lastDim !== ((seen % v.nd) == (v.nd - 1)))
                        errs++;
                end
                seen++;
            end
            expReady = expBusy && ((sent - seen) < depth) && (sent < total);
            if (inReady !== expReady) errs++;
            if (done === 1'b1) begin
                doneCnt++;
                if (dataValid !== 1'b0 || busy !== 1'b0) errs++;
            end
            if (seen == total) post++;
            if (post == 3) break;

            if (v.abortAt >= 0 && sent == v.abortAt) begin
                abort = 1'b1;
                inValid = 1'b0;
                @(negedge clk);
                check({tag, ".abortOut"}, {dataValid, busy, done, inReady}, 0);
                abort = 1'b0;
                @(negedge clk);
                if (done === 1'b1) doneCnt++;
                check({tag, ".abortIdle"}, {dataValid, busy, inReady}, 0);
                break;
            end

            if (sent >= total) begin
                inValid = 1'b1;
                inData = 32'hDEAD;
            end else begin
                case (v.mode)
                    0:       inValid = 1'b1;
                    1:       inValid = ((cyc % 24) < 20);
                    default: inValid = 1'($urandom_range(0, 1));
                endcase
                inData = (v.mode == 0) ? 32'h10 + 32'(sent) : $urandom;
            end
            #1;
            if (inValid && inReady) begin
                expQ.push_back(inData);
                sent++;
            end
            @(negedge clk);
        end
        inValid = 1'b0;
        check({tag, ".stream"}, errs, 0);
        check({tag, ".doneCount"}, doneCnt, v.expDone);
        if (v.abortAt < 0) check({tag, ".outCount"}, seen, total);
    endtask

    initial begin
        #2;
        checkReset("reset");
        @(negedge clk);
        reset = 1'b1;

        vecs.push_back('{3, 2, 0, -1, 1'b0, 1});
        vecs.push_back('{4, 8, 1, -1, 1'b0, 1});
        vecs.push_back('{0, 5, 0, -1, 1'b1, 1});
        vecs.push_back('{2, 3, 2, -1, 1'b0, 1});
        vecs.push_back('{3, 4, 0, 5, 1'b0, 0});
        vecs.push_back('{2, 1, 0, -1, 1'b0, 1});
        vecs.push_back('{5, 0, 0, -1, 1'b1, 1});
        vecs.push_back('{1, 20, 2, -1, 1'b0, 1});
        vecs.push_back('{1, 1, 0, -1, 1'b0, 1});
        for (int i = 0; i < vecs.size(); i++) doRun(i, vecs[i]);

        for (int i = 0; i < 8; i++) begin
            r.nd = $urandom_range(1, 5);
            r.np = $urandom_range(1, 6);
            r.mode = 2;
            r.abortAt = -1;
            r.expCfg = 1'b0;
            r.expDone = 1;
            doRun(50 + i, r);
        end

        @(negedge clk);
        numberOfDimensions = 2;
        numberOfPoints = 4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        inValid = 1'b1;
        inData = 32'h55;
        repeat (4) @(negedge clk);
        #3 reset = 1'b0;
        #1 checkReset("midReset");
        inValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        quietErrs = 0;
        repeat (3) begin
            @(negedge clk);
            if (dataValid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) quietErrs++;
        end
        check("postReset.quiet", quietErrs, 0);
        r.nd = 2;
        r.np = 3;
        r.mode = 0;
        r.abortAt = -1;
        r.expCfg = 1'b0;
        r.expDone = 1;
        doRun(100, r);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
